// File: rtl/mcycle.sv
// Iterative multi-cycle multiply/divide unit: shift-add multiply, restoring divide,
// signed operation via magnitudes plus a final sign correction.
module mcycle #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_COMP, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Operand magnitudes taken at capture; the most-negative value maps to 2^(WIDTH-1).
  logic             w_signed;
  logic             w_s1;
  logic             w_s2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;

  assign w_signed = ~MCycleOp[0];
  assign w_s1     = w_signed & Operand1[WIDTH-1];
  assign w_s2     = w_signed & Operand2[WIDTH-1];
  assign w_mag1   = w_s1 ? (~Operand1 + 1'b1) : Operand1;
  assign w_mag2   = w_s2 ? (~Operand2 + 1'b1) : Operand2;

  // One shift-add step: {r_hi, r_lo} holds partial product above the remaining multiplier bits.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};

  // One restoring step: r_hi is the remainder, r_lo shifts dividend out and quotient in.
  // With r_hi < divisor the top bit of the difference is a reliable borrow.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign w_shift  = {r_hi, r_lo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_div_hi = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_last;

  assign w_hi_nxt = r_is_div ? w_div_hi : w_mul_hi;
  assign w_lo_nxt = r_is_div ? w_div_lo : w_mul_lo;
  assign w_last   = (r_count == CW'(WIDTH - 1));

  // Sign correction and divide-by-zero override applied to the final iteration's values.
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_res1;
  logic [WIDTH-1:0]   w_res2;

  assign w_prod   = {w_hi_nxt, w_lo_nxt};
  assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;

  always_comb begin
    w_res1 = w_prod_s[WIDTH-1:0];
    w_res2 = w_prod_s[2*WIDTH-1:WIDTH];
    if (r_is_div) begin
      if (r_b == '0) begin
        w_res1 = '1;
        w_res2 = r_op1;
      end else begin
        w_res1 = r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
        w_res2 = r_neg_r ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
      end
    end
  end

  assign Busy = (r_state == S_COMP) || ((r_state == S_IDLE) && Start);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b      <= '0;
      r_op1    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      Result1  <= '0;
      Result2  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_is_div <= MCycleOp[1];
            r_neg_q  <= w_s1 ^ w_s2;
            r_neg_r  <= w_s1;
            r_b      <= w_mag2;
            r_op1    <= Operand1;
            r_hi     <= '0;
            r_lo     <= w_mag1;
            r_count  <= '0;
            r_state  <= S_COMP;
          end
        end
        S_COMP: begin
          r_hi    <= w_hi_nxt;
          r_lo    <= w_lo_nxt;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            Result1 <= w_res1;
            Result2 <= w_res2;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle.sv
// Self-checking bench for mcycle: arithmetic reference model checked every cycle,
// plus directed cases with hand-computed results.
module tb_mcycle;

  localparam int unsigned W = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;

  int n_chk  = 0;
  int n_fail = 0;

  mcycle #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference for one operation.
  function automatic void ref_calc(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] r1, output logic [W-1:0] r2);
    longint sa, sb, ua, ub, p, q, r;
    logic [63:0] pv, qv, rv;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (!op[1]) begin
      p  = op[0] ? ua * ub : sa * sb;
      pv = p;
      r1 = pv[W-1:0];
      r2 = pv[2*W-1:W];
    end else if (b == '0) begin
      r1 = '1;
      r2 = a;
    end else begin
      q  = op[0] ? ua / ub : sa / sb;
      r  = op[0] ? ua % ub : sa % sb;
      qv = q;
      rv = r;
      r1 = qv[W-1:0];
      r2 = rv[W-1:0];
    end
  endfunction

  // Timing model: 0 = waiting for Start, >0 = computing cycles left, -1 = result cycle.
  int           m_phase;
  logic [1:0]   m_op;
  logic [W-1:0] m_a, m_b, m_r1, m_r2;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_phase = 0;
      m_r1    = '0;
      m_r2    = '0;
    end else if (m_phase == 0) begin
      if (Start) begin
        m_op    = MCycleOp;
        m_a     = Operand1;
        m_b     = Operand2;
        m_phase = W;
      end
    end else if (m_phase > 0) begin
      m_phase--;
      if (m_phase == 0) begin
        ref_calc(m_op, m_a, m_b, m_r1, m_r2);
        m_phase = -1;
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge CLK) begin
    chk("busy", 32'(Busy), 32'((m_phase > 0) || (m_phase == 0 && Start && RESET)));
    chk("result1", 32'(Result1), 32'(m_r1));
    chk("result2", 32'(Result2), 32'(m_r2));
  end

  // Issue one operation from IDLE and wait for its result cycle.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit lit, input logic [W-1:0] e1, input logic [W-1:0] e2,
                        input bit scramble, input string name);
    int  cyc;
    bit  done;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    cyc      = 0;
    done     = 1'b0;
    @(negedge CLK);
    if (Busy) cyc++;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    if (scramble) begin
      Operand1 = W'($urandom);
      Operand2 = W'($urandom);
      MCycleOp = 2'($urandom);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!Busy) begin
        done = 1'b1;
        break;
      end
      cyc++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: Busy still high after 40 cycles", name);
    end
    if (lit) begin
      chk({name, "_busy_cycles"}, 32'(cyc), 32'(W + 1));
      chk({name, "_r1"}, 32'(Result1), 32'(e1));
      chk({name, "_r2"}, 32'(Result2), 32'(e2));
      chk({name, "_model_r1"}, 32'(m_r1), 32'(e1));
      chk({name, "_model_r2"}, 32'(m_r2), 32'(e2));
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int lows;
    bit seen_busy;
    RESET    = 1'b0;
    Start    = 1'b0;
    MCycleOp = '0;
    Operand1 = '0;
    Operand2 = '0;
    #2;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_r1", 32'(Result1), 32'd0);
    chk("reset_r2", 32'(Result2), 32'd0);
    #10 RESET = 1'b1;
    @(posedge CLK);
    #1;

    run_op(2'b01, 4'hF, 4'hF, 1, 4'h1, 4'hE, 0, "umul_ff");
    run_op(2'b00, 4'hD, 4'hD, 1, 4'h9, 4'h0, 0, "smul_m3m3");
    run_op(2'b00, 4'h7, 4'hF, 1, 4'h9, 4'hF, 0, "smul_7m1");
    run_op(2'b01, 4'h0, 4'hB, 1, 4'h0, 4'h0, 0, "umul_zero");
    run_op(2'b11, 4'h7, 4'h3, 1, 4'h2, 4'h1, 0, "udiv_7_3");
    run_op(2'b11, 4'hC, 4'h8, 1, 4'h1, 4'h4, 0, "udiv_12_8");
    run_op(2'b11, 4'h5, 4'h0, 1, 4'hF, 4'h5, 0, "udiv_by0");
    run_op(2'b10, 4'h7, 4'hD, 1, 4'hE, 4'h1, 0, "sdiv_7_m3");
    run_op(2'b10, 4'hC, 4'h2, 1, 4'hE, 4'h0, 0, "sdiv_m4_2");
    run_op(2'b10, 4'h9, 4'h2, 1, 4'hD, 4'hF, 0, "sdiv_m7_2");
    run_op(2'b10, 4'h8, 4'hF, 1, 4'h8, 4'h0, 0, "sdiv_m8_m1");
    run_op(2'b10, 4'h9, 4'h0, 1, 4'hF, 4'h9, 0, "sdiv_by0");
    run_op(2'b00, 4'h8, 4'h8, 1, 4'h0, 4'h4, 0, "smul_m8m8");
    run_op(2'b11, 4'h7, 4'h3, 1, 4'h2, 4'h1, 1, "udiv_scramble");

    // Back-to-back: Start held high; exactly one Busy-low cycle separates the ops.
    MCycleOp = 2'b01;
    Operand1 = 4'h3;
    Operand2 = 4'h5;
    Start    = 1'b1;
    lows      = 0;
    seen_busy = 1'b0;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      @(negedge CLK);
      if (!Busy && seen_busy && lows == 0) begin
        chk("b2b_first_r1", 32'(Result1), 32'h0F);
        chk("b2b_first_r2", 32'(Result2), 32'h0);
      end
      if (!Busy) lows++;
      else if (lows > 0) break;
      seen_busy = 1'b1;
      @(posedge CLK);
      #1;
      if (lows == 1) begin
        MCycleOp = 2'b11;
        Operand1 = 4'hE;
        Operand2 = 4'h4;
      end
    end
    chk("b2b_low_cycles", 32'(lows), 32'd1);
    @(posedge CLK);
    #1;
    Start = 1'b0;
    for (int i = 0; i < 40 && Busy; i++) @(posedge CLK);
    @(negedge CLK);
    chk("b2b_second_r1", 32'(Result1), 32'h3);
    chk("b2b_second_r2", 32'(Result2), 32'h2);
    @(posedge CLK);
    #1;

    // Reset mid-computation aborts and clears.
    run_op(2'b01, 4'hF, 4'hF, 0, '0, '0, 0, "pre_reset");
    MCycleOp = 2'b01;
    Operand1 = 4'hA;
    Operand2 = 4'hA;
    Start    = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    chk("midreset_busy", 32'(Busy), 32'd0);
    chk("midreset_r1", 32'(Result1), 32'd0);
    chk("midreset_r2", 32'(Result2), 32'd0);
    #7 RESET = 1'b1;
    @(posedge CLK);
    #1;
    run_op(2'b10, 4'h9, 4'h2, 1, 4'hD, 4'hF, 0, "post_reset");

    // Random operations, occasionally with idle gaps and mid-op operand changes.
    for (int n = 0; n < 200; n++) begin
      run_op(2'($urandom), W'($urandom), W'($urandom), 0, '0, '0,
             1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcycle.md
Name: mcycle

Overview:
- Iterative multi-cycle multiply/divide unit for the processor datapath's execute stage.
- Performs signed or unsigned multiplication (double-width product) and signed or unsigned division (quotient and remainder) on WIDTH-bit operands.
- Uses a Start/Busy handshake; the CPU stalls while Busy is high.

Parameters:
- WIDTH, 4, operand and result width in bits (any value >= 2; the processor overrides it to 32).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  reset, asynchronous, active-low. The name is kept for codebase consistency; low = reset.
- Start  in  1  request an operation; sampled only in IDLE.
- MCycleOp  in  2  operation: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- Operand1  in  WIDTH  multiplicand / dividend.
- Operand2  in  WIDTH  multiplier / divisor.
- Result1  out  WIDTH  mul: product low half; div: quotient.
- Result2  out  WIDTH  mul: product high half; div: remainder.
- Busy  out  1  high while an operation is pending or in progress.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE; counter and internal registers clear.
  - Result1 = 0, Result2 = 0, Busy = 0.
  - Reset mid-operation aborts the operation; no result is written.
- States: IDLE, COMPUTING, DONE.
- IDLE:
  - Busy = Start (combinational), so a stall begins in the same cycle Start is raised.
  - On a rising edge with Start=1: capture MCycleOp, Operand1 and Operand2 into internal registers, clear the iteration counter, and go to COMPUTING.
  - Input changes after capture have no effect on the current operation.
- COMPUTING:
  - Busy = 1.
  - One shift-add (mul) or restoring shift-subtract (div) iteration per cycle, for exactly WIDTH cycles.
  - The edge that completes iteration WIDTH also applies the final sign correction, writes Result1/Result2, and goes to DONE.
- DONE:
  - Busy = 0 for exactly one cycle; results are valid.
  - Start is ignored in DONE. The next state is always IDLE.
  - If Start is still high, a new operation is captured on the following edge from IDLE (back-to-back operations produce one Busy-low cycle between them).
- Latency: Start sampled at edge N; results are valid and Busy is low after edge N+WIDTH+1... precisely, results are written at edge N+WIDTH and DONE lasts from that edge to edge N+WIDTH+1.
- Result1/Result2 hold their values until the next completion or reset.
- Signed operations:
  - Take operand magnitudes (two's complement) at capture and compute unsigned.
  - Mul: negate the 2*WIDTH product if the operand signs differ.
  - Div: quotient truncates toward zero; negate the quotient if the operand signs differ. The remainder takes the dividend's sign, so Operand1 = Q*Operand2 + R always holds.
  - Most-negative operand (e.g. -8 for WIDTH=4): its magnitude is handled as unsigned 2^(WIDTH-1). Signed -8 / -1 gives Q = 0x8 (wraps), R = 0.
- Division by zero (any sign): Result1 = all ones, Result2 = Operand1 unchanged. Latency is the same as a normal operation.
- Multiply by zero gives Result1 = Result2 = 0 with normal latency; there is no early termination.
- Unsigned mul: the full 2*WIDTH product never overflows.

Test Plan:
- Unsigned mul: Op=01, 0xF*0xF -> Busy high WIDTH+1 cycles; Result1=0x1, Result2=0xE (225).
- Signed mul:
  - Op=00, 0xD*0xD (-3*-3) -> Result1=0x9, Result2=0x0.
  - Then 0x7*0xF (7*-1) -> Result1=0x9, Result2=0xF (-7).
- Unsigned div:
  - Op=11, 7/3 -> Q=0x2, R=0x1.
  - 12/8 -> Q=0x1, R=0x4.
  - 0x5/0 -> Q=0xF, R=0x5.
- Signed div:
  - Op=10, 7/-3 -> Q=0xE (-2), R=0x1.
  - -4/2 -> Q=0xE, R=0x0.
  - -7/2 -> Q=0xD (-3), R=0xF (-1).
  - -8/-1 -> Q=0x8, R=0x0.
- Handshake:
  - Start held high across two operations -> exactly one Busy-low DONE cycle between them.
  - Changing operands mid-operation does not alter the result.
- Reset: assert RESET=0 mid-COMPUTING -> Busy=0 and results 0 immediately; the next Start runs a full, correct operation.
